// File: rtl/threshold_bank_arbiter_if.sv
// Write-request handshake for requesters A (keypad) and B (remote link),
// plus the response shared by both done strobes.
interface threshold_bank_arbiter_if #(
  parameter int unsigned DATA_W = 10
);
  logic              a_valid;
  logic [2:0]        a_idx;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              a_done;
  logic              b_valid;
  logic [2:0]        b_idx;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              b_done;
  logic              resp_ok;
  logic [1:0]        resp_err;

  modport master (
    output a_valid, a_idx, a_data, b_valid, b_idx, b_data,
    input  a_ready, a_done, b_ready, b_done, resp_ok, resp_err
  );

  modport slave (
    input  a_valid, a_idx, a_data, b_valid, b_idx, b_data,
    output a_ready, a_done, b_ready, b_done, resp_ok, resp_err
  );
endinterface

// File: rtl/threshold_bank_arbiter.sv
// Irrigation threshold bank with round-robin write arbitration, range/order validation and commit.
// Optional ARB_WRITE_LOCK_EN adds input write_lock, which rejects writes with code 11 during CHECK.
module threshold_bank_arbiter #(
  parameter int unsigned         DATA_W   = 10,
  parameter int unsigned         MAX_VAL  = 1023,
  parameter logic [8*DATA_W-1:0] DEFAULTS = {10'd700, 10'd200, 10'd350, 10'd250,
                                             10'd150, 10'd900, 10'd600, 10'd300}
) (
  input  logic                    clk,
  input  logic                    reset,
  threshold_bank_arbiter_if.slave bus,
`ifdef ARB_WRITE_LOCK_EN
  input  logic                    write_lock,
`endif
  output logic [8*DATA_W-1:0]     param_flat,
  output logic                    updated,
  output logic [2:0]              upd_idx,
  output logic                    busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRANT  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] E_OK    = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_ORDER = 2'b10;
  localparam logic [1:0] E_LOCK  = 2'b11;

  localparam logic [DATA_W:0] MAX_EXT = (DATA_W+1)'(MAX_VAL);

  logic [2:0]        r_state;
  logic              r_rr;
  logic              r_win;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_err;
  logic [2:0]        r_upd_idx;
  logic [DATA_W-1:0] r_bank [8];

  logic              w_pick_b;
  logic              w_lock;
  logic              w_range_bad;
  logic              w_lo_ok;
  logic              w_hi_ok;
  logic [1:0]        w_err;

`ifdef ARB_WRITE_LOCK_EN
  assign w_lock = write_lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_pick_b = bus.b_valid && (!bus.a_valid || r_rr);

  // Group boundaries (0,3,6 low; 2,5,7 high) have no neighbour on that side.
  assign w_range_bad = (r_data == '0) || ({1'b0, r_data} > MAX_EXT);
  assign w_lo_ok = (r_idx == 3'd0) || (r_idx == 3'd3) || (r_idx == 3'd6) ||
                   (r_data > r_bank[r_idx - 3'd1]);
  assign w_hi_ok = (r_idx == 3'd2) || (r_idx == 3'd5) || (r_idx == 3'd7) ||
                   (r_data < r_bank[r_idx + 3'd1]);

  always_comb begin
    w_err = E_OK;
    if (w_lock)                  w_err = E_LOCK;
    else if (w_range_bad)        w_err = E_RANGE;
    else if (!w_lo_ok || !w_hi_ok) w_err = E_ORDER;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr      <= 1'b0;
      r_win     <= 1'b0;
      r_idx     <= '0;
      r_data    <= '0;
      r_err     <= E_OK;
      r_upd_idx <= '0;
      for (int unsigned i = 0; i < 8; i++) r_bank[i] <= DEFAULTS[i*DATA_W +: DATA_W];
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.a_valid || bus.b_valid) begin
            r_win   <= w_pick_b;
            r_rr    <= !w_pick_b;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_idx   <= r_win ? bus.b_idx  : bus.a_idx;
          r_data  <= r_win ? bus.b_data : bus.a_data;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_err <= w_err;
          if (w_err == E_OK) r_upd_idx <= r_idx;
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (r_err == E_OK) r_bank[r_idx] <= r_data;
          r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    param_flat = '0;
    for (int unsigned i = 0; i < 8; i++) param_flat[i*DATA_W +: DATA_W] = r_bank[i];
  end

  assign bus.a_ready  = (r_state == S_GRANT) && !r_win;
  assign bus.b_ready  = (r_state == S_GRANT) &&  r_win;
  assign bus.a_done   = (r_state == S_RESP)  && !r_win;
  assign bus.b_done   = (r_state == S_RESP)  &&  r_win;
  assign bus.resp_ok  = (r_state == S_RESP)  && (r_err == E_OK);
  assign bus.resp_err = (r_state == S_RESP)  ? r_err : E_OK;

  assign updated = (r_state == S_COMMIT) && (r_err == E_OK);
  assign upd_idx = r_upd_idx;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_threshold_bank_arbiter.sv
// Bench for threshold_bank_arbiter: transaction-timeline model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic from both requesters.
module tb_threshold_bank_arbiter;

  localparam int DW = 10;
  localparam logic [79:0] DEF = {10'd700, 10'd200, 10'd350, 10'd250,
                                 10'd150, 10'd900, 10'd600, 10'd300};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  threshold_bank_arbiter_if #(.DATA_W(DW)) bus ();

  logic       a_v = 1'b0, b_v = 1'b0;
  logic [2:0] a_ix = '0, b_ix = '0;
  logic [9:0] a_dt = '0, b_dt = '0;
  logic       lock = 1'b0;

  assign bus.a_valid = a_v;
  assign bus.a_idx   = a_ix;
  assign bus.a_data  = a_dt;
  assign bus.b_valid = b_v;
  assign bus.b_idx   = b_ix;
  assign bus.b_data  = b_dt;

  logic [79:0] param_flat;
  logic        updated;
  logic [2:0]  upd_idx;
  logic        busy;

  threshold_bank_arbiter #(.DATA_W(DW), .MAX_VAL(1023), .DEFAULTS(DEF)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
`ifdef ARB_WRITE_LOCK_EN
    .write_lock(lock),
`endif
    .param_flat(param_flat),
    .updated(updated),
    .upd_idx(upd_idx),
    .busy(busy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: bank contents, arbitration pointer and one in-flight transaction timeline.
  logic [9:0] m_bank [8];
  logic       m_rr = 1'b0;
  logic [2:0] m_upd = '0;
  logic       s_act = 1'b0;
  logic       s_win = 1'b0;
  int         s_c0 = 0;
  logic [2:0] s_idx = '0;
  logic [9:0] s_data = '0;
  logic [1:0] s_err = '0;

  logic [2:0] first_of [8] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 3'd6, 3'd6};
  logic [2:0] last_of  [8] = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7};

  function automatic logic [1:0] m_err(input logic [2:0] idx, input logic [9:0] d, input logic lk);
    if (lk) return 2'd3;
    if (d == 10'd0 || int'(d) > 1023) return 2'd1;
    if (idx != first_of[idx] && d <= m_bank[idx - 3'd1]) return 2'd2;
    if (idx != last_of[idx]  && d >= m_bank[idx + 3'd1]) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [9:0] pick_data(input logic [2:0] idx);
    int lo, hi, m;
    m  = int'($urandom_range(0, 5));
    lo = (idx == first_of[idx]) ? 0    : int'(m_bank[idx - 3'd1]);
    hi = (idx == last_of[idx])  ? 1024 : int'(m_bank[idx + 3'd1]);
    if (m == 0) return 10'd0;
    if (m == 1) return 10'($urandom_range(1, 1023));
    if (m == 2) return m_bank[idx];
    if (hi - lo > 1) return 10'(lo + 1 + int'($urandom_range(0, hi - lo - 2)));
    return 10'($urandom_range(1, 1023));
  endfunction

  always @(negedge clk) begin : cmp
    logic       e_ar, e_br, e_ad, e_bd, e_upd, e_done;
    logic [1:0] e_err;
    logic [79:0] e_flat;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_bank[i] = DEF[i*10 +: 10];
      m_rr  = 1'b0;
      m_upd = '0;
      s_act = 1'b0;
      chk("rst_busy",  80'(busy), 80'(0));
      chk("rst_ready", 80'({bus.a_ready, bus.b_ready}), 80'(0));
      chk("rst_done",  80'({bus.a_done, bus.b_done, bus.resp_ok}), 80'(0));
      chk("rst_err",   80'(bus.resp_err), 80'(0));
      chk("rst_upd",   80'({updated, upd_idx}), 80'(0));
      chk("rst_flat",  param_flat, DEF);
    end else begin
      if (s_act && cyc == s_c0 + 1) begin
        s_idx  = s_win ? b_ix : a_ix;
        s_data = s_win ? b_dt : a_dt;
      end
      if (s_act && cyc == s_c0 + 2) s_err = m_err(s_idx, s_data, lock);
      if (s_act && cyc == s_c0 + 3 && s_err == 2'd0) m_upd = s_idx;
      if (s_act && cyc == s_c0 + 4 && s_err == 2'd0) m_bank[s_idx] = s_data;
      e_ar   = s_act && cyc == s_c0 + 1 && !s_win;
      e_br   = s_act && cyc == s_c0 + 1 &&  s_win;
      e_done = s_act && cyc == s_c0 + 4;
      e_ad   = e_done && !s_win;
      e_bd   = e_done &&  s_win;
      e_upd  = s_act && cyc == s_c0 + 3 && s_err == 2'd0;
      e_err  = e_done ? s_err : 2'd0;
      for (int i = 0; i < 8; i++) e_flat[i*10 +: 10] = m_bank[i];
      chk("a_ready",  80'(bus.a_ready),  80'(e_ar));
      chk("b_ready",  80'(bus.b_ready),  80'(e_br));
      chk("a_done",   80'(bus.a_done),   80'(e_ad));
      chk("b_done",   80'(bus.b_done),   80'(e_bd));
      chk("resp_ok",  80'(bus.resp_ok),  80'(e_done && s_err == 2'd0));
      chk("resp_err", 80'(bus.resp_err), 80'(e_err));
      chk("updated",  80'(updated),      80'(e_upd));
      chk("upd_idx",  80'(upd_idx),      80'(m_upd));
      chk("busy",     80'(busy),         80'(s_act));
      chk("param_flat", param_flat, e_flat);
      if (s_act) begin
        if (cyc == s_c0 + 4) s_act = 1'b0;
      end else if (a_v || b_v) begin
        s_win = (a_v && b_v) ? m_rr : b_v;
        m_rr  = !s_win;
        s_c0  = cyc;
        s_act = 1'b1;
      end
    end
  end

  task automatic issue(input int r, input logic [2:0] idx, input logic [9:0] d,
                       output logic ok, output logic [1:0] err,
                       output int t0, output int tr, output int td);
    @(posedge clk); #1;
    t0 = cyc; tr = -1; td = -1; ok = 1'b0; err = 2'd0;
    if (r == 0) begin a_v = 1'b1; a_ix = idx; a_dt = d; end
    else        begin b_v = 1'b1; b_ix = idx; b_dt = d; end
    for (int k = 0; k < 60 && tr < 0; k++) begin
      @(negedge clk);
      if (r == 0 ? bus.a_ready : bus.b_ready) tr = cyc;
    end
    @(posedge clk); #1;
    if (r == 0) a_v = 1'b0; else b_v = 1'b0;
    if (tr < 0) begin
      n_chk++; n_err++;
      $display("FAIL ready_timeout requester %0d: got no ready required ready within 60 cycles", r);
      return;
    end
    for (int k = 0; k < 20 && td < 0; k++) begin
      @(negedge clk);
      if (r == 0 ? bus.a_done : bus.b_done) begin
        td = cyc; ok = bus.resp_ok; err = bus.resp_err;
      end
    end
    if (td < 0) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout requester %0d: got no done required done within 20 cycles", r);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : main
    logic ok, okb;
    logic [1:0] err, errb;
    int t0, tr, td, tb0, tbr, tbd, nd;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_reset_flat", param_flat, DEF);
    chk("lit_reset_busy", 80'(busy), 80'(0));
    #1 reset = 1'b0;

    issue(0, 3'd1, 10'd450, ok, err, t0, tr, td);
    chk("lit_a_ok",      80'({ok, err}), 80'(3'b100));
    chk("lit_ready_lat", 80'(tr - t0), 80'(1));
    chk("lit_done_lat",  80'(td - t0), 80'(4));
    chk("lit_entry1",    80'(param_flat[19:10]), 80'(450));

    issue(1, 3'd0, 10'd650, ok, err, t0, tr, td);
    chk("lit_order_err", 80'({ok, err}), 80'(3'b010));
    chk("lit_entry0",    80'(param_flat[9:0]), 80'(300));

    pulse_reset();
    fork
      issue(0, 3'd2, 10'd950, ok, err, t0, tr, td);
      issue(1, 3'd4, 10'd200, okb, errb, tb0, tbr, tbd);
    join
    chk("lit_pair1_a_first", 80'(tr - t0),  80'(1));
    chk("lit_pair1_b_next",  80'(tbr - t0), 80'(6));
    chk("lit_pair1_resp",    80'({ok, err, okb, errb}), 80'(6'b100100));
    issue(0, 3'd3, 10'd100, ok, err, t0, tr, td);
    chk("lit_single_a", 80'({ok, err}), 80'(3'b100));
    fork
      issue(0, 3'd5, 10'd400, ok, err, t0, tr, td);
      issue(1, 3'd1, 10'd700, okb, errb, tb0, tbr, tbd);
    join
    chk("lit_pair2_b_first", 80'(tbr - tb0), 80'(1));
    chk("lit_pair2_a_next",  80'(tr - t0),   80'(6));

    issue(0, 3'd6, 10'd0, ok, err, t0, tr, td);
    chk("lit_range_err", 80'({ok, err}), 80'(3'b001));
    issue(0, 3'd7, 10'd201, ok, err, t0, tr, td);
    chk("lit_rain_yes_ok", 80'({ok, err}), 80'(3'b100));
    chk("lit_entry7",      80'(param_flat[79:70]), 80'(201));

    @(posedge clk); #1;
    a_v = 1'b1; a_ix = 3'd2; a_dt = 10'd950;
    tr = -1;
    for (int k = 0; k < 20 && tr < 0; k++) begin
      @(negedge clk);
      if (bus.a_ready) tr = cyc;
    end
    chk("lit_midop_ready_seen", 80'(tr >= 0), 80'(1));
    @(posedge clk); #1;
    a_v = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.a_done || bus.b_done) nd++;
    end
    chk("lit_midop_no_done", 80'(nd), 80'(0));
    chk("lit_midop_flat",    param_flat, DEF);

`ifdef ARB_WRITE_LOCK_EN
    lock = 1'b1;
    issue(0, 3'd1, 10'd500, ok, err, t0, tr, td);
    chk("lit_lock_err",   80'({ok, err}), 80'(3'b011));
    chk("lit_lock_entry", 80'(param_flat[19:10]), 80'(600));
    chk("lit_lock_lat",   80'(td - t0), 80'(4));
    lock = 1'b0;
`endif

    fork
      begin
        logic okr; logic [1:0] er; int x0, xr, xd; logic [2:0] ix;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
`ifdef ARB_WRITE_LOCK_EN
          lock = ($urandom_range(0, 4) == 0);
`endif
          ix = 3'($urandom_range(0, 7));
          issue(0, ix, pick_data(ix), okr, er, x0, xr, xd);
        end
      end
      begin
        logic okr; logic [1:0] er; int x0, xr, xd; logic [2:0] ix;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          ix = 3'($urandom_range(0, 7));
          issue(1, ix, pick_data(ix), okr, er, x0, xr, xd);
        end
      end
    join
    lock = 1'b0;

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
